// File: rtl/basys3_io_pkg.sv
// Shared board-level constants for the Basys3 I/O blocks.
// No ports; imported by sw_debouncer and debounce_bit.
package basys3_io_pkg;

  localparam int unsigned CLK_FREQ_HZ = 100_000_000;

  // 10 ms of settling at the board clock rate.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 100;

  // Width of a counter that can hold 0..cycles.
  function automatic int unsigned debounce_cnt_w(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single switch debouncer: two-flop synchronizer, stability counter,
// accepted level and registered rise/fall pulses.
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   sw_in              raw asynchronous switch level
//   sw_out             debounced level (registered)
//   rise, fall         one-cycle pulses on sw_out 0->1 / 1->0 (registered)
//   accept_next        high in the cycle before sw_out changes; lets the
//                      parent register a summary pulse aligned with rise/fall
module debounce_bit
  import basys3_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = debounce_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_in,
  output logic sw_out,
  output logic rise,
  output logic fall,
  output logic accept_next
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  logic w_differ;
  logic w_accept;

  assign w_differ = r_sync2 ^ r_level;
  // Accept on the edge where the count has reached its last value; the
  // counter therefore never goes past LAST_CNT.
  assign w_accept = w_differ && (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
      r_rise  <= w_accept & r_sync2;
      r_fall  <= w_accept & ~r_sync2;
      if (!w_differ) begin
        // Any return to the accepted level discards the partial count.
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign sw_out      = r_level;
  assign rise        = r_rise;
  assign fall        = r_fall;
  assign accept_next = w_accept;

endmodule

// File: rtl/sw_debouncer.sv
// Debounces WIDTH independent board switches.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   sw_in          raw asynchronous switch levels
//   sw_out         debounced levels (registered)
//   rise, fall     per-bit one-cycle edge pulses (registered)
//   changed        one-cycle pulse when any bit pulses rise or fall
module sw_debouncer
  import basys3_io_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] w_accept;
  logic             r_changed;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk         (clk),
      .reset_n     (reset_n),
      .sw_in       (sw_in[g]),
      .sw_out      (sw_out[g]),
      .rise        (rise[g]),
      .fall        (fall[g]),
      .accept_next (w_accept[g])
    );
  end

  // Registered from the per-bit accept strobes so it lands in the same
  // cycle as rise/fall rather than one cycle after them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_accept;
    end
  end

  assign changed = r_changed;

endmodule

// File: doc/sw_debouncer.md
SW_DEBOUNCER -- requirements
Module: sw_debouncer

Interface
REQ-001 Parameter WIDTH, default 16, number of independent switch inputs debounced.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable clk cycles (10 ms at 100 MHz) required to accept a new level; legal range >= 1.
REQ-003 Localparam CNT_W, equal to $clog2(DEBOUNCE_CYCLES+1), is the width of each per-bit stability counter.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 sw_in  input  WIDTH  raw asynchronous board switch levels.
REQ-007 sw_out  output  WIDTH  debounced, clk-synchronous switch levels, registered.
REQ-008 rise  output  WIDTH  one-cycle pulse per bit when sw_out bit goes 0->1, registered.
REQ-009 fall  output  WIDTH  one-cycle pulse per bit when sw_out bit goes 1->0, registered.
REQ-010 changed  output  1  one-cycle pulse, OR-reduction of rise|fall, registered in the same cycle as the pulses.

Function
REQ-011 Each bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-012 Each bit SHALL be fully independent; activity on one bit never affects another bit's counter, level or pulses.
REQ-013 Per bit, while sync2 equals sw_out, the counter SHALL be held at 0.
REQ-014 Per bit, while sync2 differs from sw_out, the counter SHALL increment by 1 each cycle.
REQ-015 When the counter equals DEBOUNCE_CYCLES-1 and sync2 still differs, sw_out SHALL take sync2 at that edge and the counter SHALL clear to 0.
REQ-016 Any cycle where sync2 returns to sw_out before acceptance SHALL clear the counter; partial counts never accumulate across glitches.
REQ-017 Latency: a clean level change sampled at edge E0 SHALL appear on sw_out at edge E0+DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges inclusive).
REQ-018 rise/fall SHALL be asserted in exactly the cycle sw_out transitions and SHALL be 0 in every other cycle.
REQ-019 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around.
REQ-020 With DEBOUNCE_CYCLES=1, every sync2 change SHALL be accepted on the next edge (pure synchronizer + edge detector).
REQ-021 Multiple bits transitioning in the same cycle SHALL each pulse rise/fall; changed SHALL pulse once for that cycle.
REQ-022 An input toggling faster than DEBOUNCE_CYCLES SHALL never change sw_out.

Reset
REQ-023 While reset_n is low at a clk edge, sync1, sync2, counters, sw_out, rise, fall and changed SHALL all become 0.
REQ-024 Reset asserted mid-count SHALL abandon the count; no pulse is generated for the aborted transition.
REQ-025 After reset release, a switch already high SHALL be treated as a new 0->1 change and produce a rise pulse after the REQ-017 latency.

Structure
REQ-026 CLK_FREQ_HZ (100_000_000) and DEFAULT_DEBOUNCE_CYCLES SHALL live in the shared basys3_io_pkg package; sw_debouncer's DEBOUNCE_CYCLES default SHALL reference it.
REQ-027 A single-bit sub-module debounce_bit (sync, counter, level, rise, fall) SHALL be instantiated WIDTH times with a generate loop; sw_debouncer adds only the changed reduction register.
REQ-028 No state machine beyond the per-bit counter/level pair; no combinational path from sw_in to any output.

Verification (bench uses WIDTH=16, DEBOUNCE_CYCLES=4)
REQ-029 Reset with sw_in=16'hFFFF held -> all outputs 0 during reset; 6 edges after release sw_out=16'hFFFF, rise=16'hFFFF and changed=1 for exactly one cycle.
REQ-030 Bit 3 raised cleanly from 0 -> sw_out[3]=1 at edge E0+5, rise[3] one cycle, no other bit changes.
REQ-031 Bit 0 toggled every 2 cycles for 40 cycles -> sw_out[0], rise[0], fall[0] stay 0 throughout.
REQ-032 Bits 15 and 7 cleared in the same cycle from 1 -> fall=16'h8080 for one cycle, changed pulses once.
REQ-033 Reset asserted 2 cycles into a bit-5 count, released with sw_in[5]=0 -> no pulse on bit 5, counter restarts at 0.
REQ-034 Random glitch stress, 10k cycles, reference model comparison -> sw_out/rise/fall match model every cycle, changed equals |(rise|fall).
